// File: rtl/uart_ss_rx.sv
// UART receive stage: 2-FF line synchroniser, start-edge qualified by the
// upstream falling-edge pulse, centre sampling, LSB-first shift, optional
// parity and stop-bit checks, one-cycle valid strobe with error flags.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for i_fall_pulse
// ST_START  | timing half a bit to the start-bit centre, rejects glitches
// ST_DATA   | sampling DATA_BITS data bits, LSB first
// ST_PARITY | sampling the parity bit (only when PARITY_EN)
// ST_STOP   | sampling the stop bit, then publishing the byte
module uart_ss_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_rx,
   input  logic                 i_fall_pulse,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_IDX    = IW'(DATA_BITS - 1);
   localparam logic          ODD         = (PARITY_ODD != 0);
   localparam logic          HAS_PARITY  = (PARITY_EN != 0);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic                 sync_1;
   logic                 rx_s;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 sample;

   // Sample event at bit centre; never in IDLE, where the counter is parked.
   assign sample = (state != ST_IDLE) && (cnt == '0);
   assign o_busy = (state != ST_IDLE);

   // Two-flop synchroniser, reset to the idle-high line level.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_1 <= 1'b1;
         rx_s   <= 1'b1;
      end else begin
         sync_1 <= i_rx;
         rx_s   <= sync_1;
      end
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic; the fall pulse only matters in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (i_fall_pulse) state_nxt = ST_START;
         ST_START:  if (sample) state_nxt = rx_s ? ST_IDLE : ST_DATA;
         ST_DATA:   if (sample && (idx == LAST_IDX))
                       state_nxt = HAS_PARITY ? ST_PARITY : ST_STOP;
         ST_PARITY: if (sample) state_nxt = ST_STOP;
         ST_STOP:   if (sample) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Baud down-counter, bit index, shift register and parity capture.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
      end else begin
         if (state == ST_IDLE) begin
            if (i_fall_pulse) cnt <= HALF_RELOAD;
         end else if (sample) begin
            cnt <= FULL_RELOAD;
         end else begin
            cnt <= cnt - CW'(1);
         end
         if (sample) begin
            case (state)
               ST_START:  idx <= '0;
               ST_DATA: begin
                  shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                  idx   <= idx + IW'(1);
               end
               ST_PARITY: par_bit <= rx_s;
               default:   ;
            endcase
         end
      end
   end

   // Output register: strobe and flags live for exactly one cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
      end else begin
         o_valid      <= 1'b0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
         if (sample && (state == ST_STOP)) begin
            o_data       <= shreg;
            o_valid      <= 1'b1;
            o_frame_err  <= ~rx_s;
            o_parity_err <= HAS_PARITY & ((^shreg) ^ par_bit ^ ODD);
         end
      end
   end

endmodule

// File: tb/tb_uart_ss_rx.sv
// Directed bench for uart_ss_rx: an 8N1 instance and an 8E1 instance share
// the serial line and the start pulse; each one's strobes are logged.
module tb_uart_ss_rx;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      logic       busy;
      logic       busy_prev;
      int         cyc;
   } rec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic       fall;
   logic [7:0] a_data, b_data;
   logic       a_valid, a_perr, a_ferr, a_busy;
   logic       b_valid, b_perr, b_ferr, b_busy;
   logic       a_busy_q = 1'b0;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   rec_t       qa[$];
   rec_t       qb[$];

   uart_ss_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .i_fall_pulse(fall),
      .o_data(a_data), .o_valid(a_valid), .o_parity_err(a_perr),
      .o_frame_err(a_ferr), .o_busy(a_busy));

   uart_ss_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .i_fall_pulse(fall),
      .o_data(b_data), .o_valid(b_valid), .o_parity_err(b_perr),
      .o_frame_err(b_ferr), .o_busy(b_busy));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (a_valid) qa.push_back('{a_data, a_perr, a_ferr, a_busy, a_busy_q, cyc});
      if (b_valid) qb.push_back('{b_data, b_perr, b_ferr, b_busy, 1'b0, cyc});
      a_busy_q = a_busy;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pop(inout rec_t q[$], output rec_t r);
      if (q.size() > 0) r = q.pop_front();
      else r = '{8'hxx, 1'bx, 1'bx, 1'bx, 1'bx, -1};
   endtask

   // Drives one frame: rx falls at cycle S, pulse at S+2 (synchroniser
   // latency). limit > 0 stops driving after that many cycles.
   task automatic send(input logic [7:0] d, input logic has_par, input logic par_bit,
                       input logic stop_bit, input int gap, input int limit,
                       output int t_pulse);
      logic [10:0] line;
      int nb;
      int n;
      line = '1;
      line[0] = 1'b0;
      for (int i = 0; i < 8; i++) line[1+i] = d[i];
      if (has_par) begin
         line[9]  = par_bit;
         line[10] = stop_bit;
         nb = 11;
      end else begin
         line[9] = stop_bit;
         nb = 10;
      end
      n = (limit > 0) ? limit : nb * 16;
      t_pulse = -1;
      for (int i = 0; i < n; i++) begin
         rx   = line[i/16];
         fall = (i == 2);
         if (i == 2) t_pulse = cyc;
         tick();
      end
      fall = 1'b0;
      if (limit == 0) begin
         rx = 1'b1;
         repeat (gap) tick();
      end
   endtask

   initial begin
      rec_t r;
      int   t;
      rst_n = 1'b0;
      rx    = 1'b1;
      fall  = 1'b0;
      repeat (3) tick();
      chk("rst_valid", {31'd0, a_valid}, 0);
      chk("rst_data",  {24'd0, a_data}, 0);
      chk("rst_flags", {30'd0, a_perr, a_ferr}, 0);
      chk("rst_busy",  {30'd0, a_busy, b_busy}, 0);
      rst_n = 1'b1;
      repeat (5) tick();

      // 0x55 8N1: strobe exactly 153 cycles after the pulse
      qa.delete();
      send(8'h55, 1'b0, 1'b0, 1'b1, 20, 0, t);
      chk("t1_count", qa.size(), 1);
      pop(qa, r);
      chk("t1_cycle", r.cyc, t + 153);
      chk("t1_data",  {24'd0, r.data}, 32'h55);
      chk("t1_perr",  {31'd0, r.perr}, 0);
      chk("t1_ferr",  {31'd0, r.ferr}, 0);
      chk("t1_busy_at_valid", {31'd0, r.busy}, 0);
      chk("t1_busy_before",   {31'd0, r.busy_prev}, 1);

      // False start: three low cycles, rejected at the start sample
      qa.delete();
      rx = 1'b0;
      tick(); tick();
      fall = 1'b1;
      t = cyc;
      tick();
      fall = 1'b0;
      rx   = 1'b1;
      while (cyc < t + 8) tick();
      @(negedge clk);
      chk("t2_busy_at_sample", {31'd0, a_busy}, 1);
      tick();
      @(negedge clk);
      chk("t2_busy_after", {31'd0, a_busy}, 0);
      repeat (200) tick();
      chk("t2_no_valid", qa.size(), 0);

      // Framing error then a clean frame
      qa.delete();
      send(8'hA3, 1'b0, 1'b0, 1'b0, 20, 0, t);
      send(8'h0F, 1'b0, 1'b0, 1'b1, 20, 0, t);
      chk("t3_count", qa.size(), 2);
      pop(qa, r);
      chk("t3_a3_data", {24'd0, r.data}, 32'hA3);
      chk("t3_a3_ferr", {31'd0, r.ferr}, 1);
      chk("t3_a3_perr", {31'd0, r.perr}, 0);
      pop(qa, r);
      chk("t3_0f_data", {24'd0, r.data}, 32'h0F);
      chk("t3_0f_ferr", {31'd0, r.ferr}, 0);

      // Even parity on the 8E1 instance: 0x07 needs parity bit 1
      repeat (200) tick();
      qb.delete();
      send(8'h07, 1'b1, 1'b0, 1'b1, 30, 0, t);
      send(8'h07, 1'b1, 1'b1, 1'b1, 30, 0, t);
      chk("t4_count", qb.size(), 2);
      pop(qb, r);
      chk("t4_bad_perr", {31'd0, r.perr}, 1);
      pop(qb, r);
      chk("t4_good_perr", {31'd0, r.perr}, 0);
      chk("t4_good_data", {24'd0, r.data}, 32'h07);
      chk("t4_good_cycle", r.cyc, t + 169);
      chk("t4_good_ferr", {31'd0, r.ferr}, 0);

      // Back-to-back frames, no idle gap
      repeat (50) tick();
      qa.delete();
      send(8'h12, 1'b0, 1'b0, 1'b1, 0, 0, t);
      send(8'h34, 1'b0, 1'b0, 1'b1, 20, 0, t);
      chk("t5_count", qa.size(), 2);
      pop(qa, r);
      chk("t5_first",  {24'd0, r.data}, 32'h12);
      pop(qa, r);
      chk("t5_second", {24'd0, r.data}, 32'h34);

      // Reset while receiving data bit 3, then a clean 0xC6
      send(8'h5A, 1'b0, 1'b0, 1'b1, 0, 70, t);
      chk("t6_busy_pre", {31'd0, a_busy}, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", {31'd0, a_valid}, 0);
      chk("t6_rst_data",  {24'd0, a_data}, 0);
      chk("t6_rst_flags", {30'd0, a_perr, a_ferr}, 0);
      chk("t6_rst_busy",  {30'd0, a_busy, b_busy}, 0);
      rx = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (40) tick();
      qa.delete();
      send(8'hC6, 1'b0, 1'b0, 1'b1, 20, 0, t);
      chk("t6_count", qa.size(), 1);
      pop(qa, r);
      chk("t6_data", {24'd0, r.data}, 32'hC6);
      chk("t6_ferr", {31'd0, r.ferr}, 0);
      chk("t6_cycle", r.cyc, t + 153);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
